sram2rw_ctrl: RTL
=================

SRAM2RW_CTRL -- requirements
Module: sram2rw_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, the SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 4, the SRAM word width.
REQ-003 SHALL have parameter DEPTH, default 64, the number of SRAM words (2**ADDR_W).
REQ-004 SHALL have one clock and a synchronous active-high reset: `clock  in  1  sole clock; the SRAM CE1/CE2 are tied to it externally`.
REQ-005 SHALL have port `reset  in  1  synchronous, active-high`.
REQ-006 SHALL provide, per channel N in {1,2}, port `reqN_valid  in  1  request present`.
REQ-007 SHALL provide port `reqN_ready  out  1  request accepted when valid&&ready`.
REQ-008 SHALL provide port `reqN_write  in  1  1=write, 0=read`.
REQ-009 SHALL provide ports `reqN_addr  in  ADDR_W  word address` and `reqN_wdata  in  DATA_W  write data`.
REQ-010 SHALL provide ports `respN_valid  out  1`, `respN_ready  in  1` and `respN_rdata  out  DATA_W`, forming the read-response channel.
REQ-011 SHALL provide SRAM-side ports `sram_csbN/sram_webN/sram_oebN  out  1  active-low`, `sram_aN  out  ADDR_W`, `sram_iN  out  DATA_W` and `sram_oN  in  DATA_W`.
REQ-012 SHALL provide port `init_done  out  1  high once the scrub completes`.

Function
REQ-013 SHALL implement a top FSM with states RESET_IDLE, INIT and RUN: reset drives it to RESET_IDLE, the next cycle moves to INIT, and INIT moves to RUN after the write to address DEPTH-1.
REQ-014 In INIT, SHALL write zero via port 1 (csb1=0, web1=0, oeb1=1, a1 = a counter running 0..DEPTH-1) for exactly DEPTH cycles, hold port 2 idle, and hold both reqN_ready at 0.
REQ-015 In RUN, SHALL drive the SRAM pins combinationally from the accept signal: csbN = !(reqN_valid && reqN_ready), webN = !reqN_write, oebN = reqN_write, aN = reqN_addr, iN = reqN_wdata.
REQ-016 SHALL accept reads and writes on both channels in any mix, one per channel per cycle.
REQ-017 SHALL produce no response for writes.
REQ-018 SHALL, for a read accepted in cycle T, capture sram_oN at the end of cycle T+1 into channel N's 2-entry response FIFO, so that respN_valid rises no earlier than cycle T+2.
REQ-019 SHALL drive reqN_ready = RUN && (fifo_count + inflight) < 2 for reads; writes are gated only by RUN and the collision rule.
REQ-020 SHALL treat a same-cycle access from both channels to the same address as a collision if either access is a write.
REQ-021 SHALL resolve a collision with port 1 priority: req2_ready=0 that cycle, and port 2 retries.
REQ-022 SHALL allow a read-read access to the same address concurrently.
REQ-023 SHALL deliver responses strictly in per-channel request order.
REQ-024 SHALL, when the response FIFO holds 2 entries and respN_ready=0, hold respN_rdata stable and refuse new reads.
REQ-025 SHALL allow a FIFO pop and push in the same cycle, with no bubble.
REQ-026 SHALL keep respN_rdata equal to the FIFO head whenever respN_valid=1; otherwise respN_rdata is don't-care.
REQ-027 SHALL raise init_done at the first RUN cycle and hold it until reset.

Reset
REQ-028 SHALL, while reset is high, drive reqN_ready=0, respN_valid=0, init_done=0, csbN=webN=oebN=1, aN=0 and iN=0.
REQ-029 SHALL, on a reset asserted mid-operation, discard in-flight reads, empty both FIFOs, clear the INIT counter and re-run INIT; no response issued before the reset appears afterwards.

Structure
REQ-030 SHALL place ADDR_W, DATA_W, DEPTH and the FSM state enum (RESET_IDLE, INIT, RUN) in package sram2rw_pkg.
REQ-031 SHALL implement the response FIFO as sub-module sram2rw_resp_fifo (2-entry, valid/ready, synchronous reset), instantiated once per channel.

Verification
REQ-032 The bench SHALL check init scrub: release reset, then expect init_done after exactly 65 cycles, with every address reading 0x0 on both ports.
REQ-033 The bench SHALL check write-then-read: port1 writes addr 5 = 0xA, then port2 reads addr 5 on the next cycle, and resp2 must return 0xA two cycles after acceptance.
REQ-034 The bench SHALL check a collision: both ports valid at addr 12, port1 writing 0x3 and port2 writing 0x7, and expect req2_ready=0, port1 completing, port2 completing one cycle later, and a final read of 0x7.
REQ-035 The bench SHALL check backpressure: resp1_ready=0 while port1 issues 4 back-to-back reads, and expect exactly 2 accepted, req1_ready=0 after that, and the remaining reads accepted in order once ready=1, each data value correct.
REQ-036 The bench SHALL check read-read: both ports read addr 40 (holding 0x9) in the same cycle, and expect both accepted and both responses equal to 0x9.
REQ-037 The bench SHALL check mid-operation reset: assert reset with 2 responses queued and 1 read in flight, and expect resp valid=0, all csb=1, INIT to re-run, and no stale response afterwards.

Source files
------------

// File: rtl/sram2rw_pkg.sv
// Shared parameters and top-level FSM state encoding for the dual-port
// SRAM controller.
package sram2rw_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 64;

    typedef enum logic [1:0] {
        RESET_IDLE = 2'd0,
        INIT       = 2'd1,
        RUN        = 2'd2
    } top_state_t;

endpackage

// File: rtl/sram2rw_resp_fifo.sv
// Two-entry read-response FIFO with valid/ready on both sides; a push and a
// pop may happen in the same cycle, including when full.
module sram2rw_resp_fifo #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              push;
    logic              pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign in_ready  = (count != 2'd2) || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/sram2rw_ctrl.sv
// Dual-channel controller for a 2RW SRAM macro: zero-scrubs the array after
// reset, then maps each request channel onto one SRAM port.
module sram2rw_ctrl #(
    parameter int ADDR_W = sram2rw_pkg::ADDR_W,
    parameter int DATA_W = sram2rw_pkg::DATA_W,
    parameter int DEPTH  = sram2rw_pkg::DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_rdata,
    input  logic              req2_valid,
    output logic              req2_ready,
    input  logic              req2_write,
    input  logic [ADDR_W-1:0] req2_addr,
    input  logic [DATA_W-1:0] req2_wdata,
    output logic              resp2_valid,
    input  logic              resp2_ready,
    output logic [DATA_W-1:0] resp2_rdata,
    output logic              sram_csb1,
    output logic              sram_web1,
    output logic              sram_oeb1,
    output logic [ADDR_W-1:0] sram_a1,
    output logic [DATA_W-1:0] sram_i1,
    input  logic [DATA_W-1:0] sram_o1,
    output logic              sram_csb2,
    output logic              sram_web2,
    output logic              sram_oeb2,
    output logic [ADDR_W-1:0] sram_a2,
    output logic [DATA_W-1:0] sram_i2,
    input  logic [DATA_W-1:0] sram_o2,
    output logic              init_done,
    output logic [1:0]        dbg_state
);

    import sram2rw_pkg::*;

    // Handshake: a transfer happens on the clock edge ending any cycle in which
    // valid && ready; valid must not wait for ready, ready may depend on valid.

    top_state_t        state;
    top_state_t        state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic              rd_pend1;
    logic              rd_pend2;
    logic              run;
    logic              acc1;
    logic              acc2;
    logic              collide;
    logic              rd_room1;
    logic              rd_room2;
    logic              fifo1_valid;
    logic              fifo2_valid;
    logic              fifo1_in_ready;
    logic              fifo2_in_ready;
    logic [1:0]        fifo1_cnt;
    logic [1:0]        fifo2_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RESET_IDLE;
            init_cnt <= '0;
            rd_pend1 <= 1'b0;
            rd_pend2 <= 1'b0;
        end else begin
            state    <= state_nxt;
            if (state == INIT) begin
                init_cnt <= init_cnt + ADDR_W'(1);
            end
            rd_pend1 <= acc1 && !req1_write;
            rd_pend2 <= acc2 && !req2_write;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RESET_IDLE: state_nxt = INIT;
            INIT:       if (init_cnt == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
            RUN:        state_nxt = RUN;
            default:    state_nxt = RESET_IDLE;
        endcase
    end

    // Outputs are masked by reset directly so the pins go idle in the very
    // cycle reset is raised, not one edge later.
    assign run       = (state == RUN) && !reset;
    assign init_done = run;
    assign dbg_state = state;

    // A read may only be accepted if its response is guaranteed a FIFO slot.
    assign rd_room1 = fifo1_in_ready && ((fifo1_cnt + {1'b0, rd_pend1}) < 2'd2);
    assign rd_room2 = fifo2_in_ready && ((fifo2_cnt + {1'b0, rd_pend2}) < 2'd2);

    assign req1_ready = run && (req1_write || rd_room1);
    assign acc1       = req1_valid && req1_ready;
    assign collide    = acc1 && req2_valid && (req1_addr == req2_addr)
                        && (req1_write || req2_write);
    assign req2_ready = run && (req2_write || rd_room2) && !collide;
    assign acc2       = req2_valid && req2_ready;

    always_comb begin
        sram_csb1 = 1'b1;
        sram_web1 = 1'b1;
        sram_oeb1 = 1'b1;
        sram_a1   = '0;
        sram_i1   = '0;
        sram_csb2 = 1'b1;
        sram_web2 = 1'b1;
        sram_oeb2 = 1'b1;
        sram_a2   = '0;
        sram_i2   = '0;
        if (!reset) begin
            case (state)
                INIT: begin
                    sram_csb1 = 1'b0;
                    sram_web1 = 1'b0;
                    sram_a1   = init_cnt;
                end
                RUN: begin
                    sram_csb1 = !acc1;
                    sram_web1 = !req1_write;
                    sram_oeb1 = req1_write;
                    sram_a1   = req1_addr;
                    sram_i1   = req1_wdata;
                    sram_csb2 = !acc2;
                    sram_web2 = !req2_write;
                    sram_oeb2 = req2_write;
                    sram_a2   = req2_addr;
                    sram_i2   = req2_wdata;
                end
                default: ;
            endcase
        end
    end

    sram2rw_resp_fifo #(.DATA_W(DATA_W)) u_fifo1 (
        .clk       (clock),
        .rst       (reset),
        .in_valid  (rd_pend1),
        .in_ready  (fifo1_in_ready),
        .in_data   (sram_o1),
        .out_valid (fifo1_valid),
        .out_ready (resp1_ready && !reset),
        .out_data  (resp1_rdata),
        .count     (fifo1_cnt)
    );

    sram2rw_resp_fifo #(.DATA_W(DATA_W)) u_fifo2 (
        .clk       (clock),
        .rst       (reset),
        .in_valid  (rd_pend2),
        .in_ready  (fifo2_in_ready),
        .in_data   (sram_o2),
        .out_valid (fifo2_valid),
        .out_ready (resp2_ready && !reset),
        .out_data  (resp2_rdata),
        .count     (fifo2_cnt)
    );

    assign resp1_valid = fifo1_valid && !reset;
    assign resp2_valid = fifo2_valid && !reset;

endmodule
